// File: rtl/ctl_shot.sv
// ctl_shot: shot/hit arbiter feeding the duck controller's hit input.
// Decides which trigger presses become shots, tests each shot against the
// duck hitbox, tracks ammo per duck appearance, cooldown and score.
//
// Build option: CTL_SHOT_BONUS_EN
//   A hit on the first shot of an appearance scores 2 instead of 1.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   new_frame    one-cycle pulse per video frame
//   game_start   one-cycle pulse: clear score, reload ammo, arm
//   trigger      raw asynchronous trigger level
//   aim_x/aim_y  crosshair position
//   duck_x/y     duck top-left corner
//   duck_show    duck visible
//   duck_hit     duck already falling
//   hit          high while the hit is being held (HIT_HOLD frames)
//   shot_fired   one-cycle pulse per accepted shot
//   shots_left   remaining ammo
//   score        saturating hit count
//   miss         one-cycle pulse when ammo runs out without a hit
module ctl_shot #(
  parameter int DUCK_W          = 64,
  parameter int DUCK_H          = 64,
  parameter int SHOTS           = 3,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int HIT_HOLD_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       game_start,
  input  logic       trigger,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic [9:0] duck_x,
  input  logic [9:0] duck_y,
  input  logic       duck_show,
  input  logic       duck_hit,
  output logic       hit,
  output logic       shot_fired,
  output logic [1:0] shots_left,
  output logic [7:0] score,
  output logic       miss
);

  localparam logic [1:0]  LP_SHOTS = 2'(SHOTS);
  localparam logic [5:0]  LP_CD    = 6'(COOLDOWN_FRAMES);
  localparam logic [3:0]  LP_HOLD  = 4'(HIT_HOLD_FRAMES);
  localparam logic [10:0] LP_W     = 11'(DUCK_W);
  localparam logic [10:0] LP_H     = 11'(DUCK_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COOL,
    S_HOLD,
    S_EMPTY
  } state_t;

  state_t      r_state;
  logic        r_meta;
  logic        r_sync_q;
  logic        r_sync_qq;
  logic        r_show_d;
  logic [5:0]  r_cd;
  logic [3:0]  r_hold;
  logic        r_hit;
  logic        r_shot;
  logic        r_miss;
  logic [1:0]  r_shots_left;
  logic [7:0]  r_score;

  logic        w_press;
  logic        w_show_rise;
  logic        w_inside;
  logic        w_fire;
  logic        w_last_shot;
  logic [1:0]  w_pts;
  logic [8:0]  w_score_sum;
  logic [7:0]  w_score_next;
  logic [10:0] w_ax;
  logic [10:0] w_ay;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_dx_end;
  logic [10:0] w_dy_end;

  // Two flops of synchroniser, a third for the edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta    <= 1'b0;
      r_sync_q  <= 1'b0;
      r_sync_qq <= 1'b0;
    end else begin
      r_meta    <= trigger;
      r_sync_q  <= r_meta;
      r_sync_qq <= r_sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_show_d <= 1'b0;
    end else begin
      r_show_d <= duck_show;
    end
  end

  assign w_press     = r_sync_q & ~r_sync_qq;
  assign w_show_rise = duck_show & ~r_show_d;

  // 11-bit math so a duck near the right/bottom edge cannot wrap.
  assign w_ax     = {1'b0, aim_x};
  assign w_ay     = {1'b0, aim_y};
  assign w_dx     = {1'b0, duck_x};
  assign w_dy     = {1'b0, duck_y};
  assign w_dx_end = w_dx + LP_W;
  assign w_dy_end = w_dy + LP_H;

  assign w_inside = (w_ax >= w_dx) && (w_ax < w_dx_end) &&
                    (w_ay >= w_dy) && (w_ay < w_dy_end);

  assign w_fire = w_press && (r_shots_left != 2'd0) &&
                  duck_show && !duck_hit;

  // A same-cycle reload keeps ammo from hitting zero.
  assign w_last_shot = (r_shots_left == 2'd1) && !w_show_rise;

`ifdef CTL_SHOT_BONUS_EN
  assign w_pts = (r_shots_left == LP_SHOTS) ? 2'd2 : 2'd1;
`else
  assign w_pts = 2'd1;
`endif

  assign w_score_sum  = {1'b0, r_score} + {7'b0, w_pts};
  assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cd         <= '0;
      r_hold       <= '0;
      r_hit        <= 1'b0;
      r_shot       <= 1'b0;
      r_miss       <= 1'b0;
      r_shots_left <= LP_SHOTS;
      r_score      <= '0;
    end else begin
      r_shot <= 1'b0;
      r_miss <= 1'b0;
      if (game_start) begin
        r_state      <= S_ARMED;
        r_cd         <= '0;
        r_hold       <= '0;
        r_hit        <= 1'b0;
        r_shots_left <= LP_SHOTS;
        r_score      <= '0;
      end else begin
        if (w_show_rise) begin
          r_shots_left <= LP_SHOTS;
        end
        case (r_state)
          S_IDLE: begin
          end
          S_ARMED: begin
            if (w_fire) begin
              r_shot <= 1'b1;
              r_cd   <= LP_CD;
              if (!w_show_rise) begin
                r_shots_left <= r_shots_left - 2'd1;
              end
              if (w_inside) begin
                r_state <= S_HOLD;
                r_hit   <= 1'b1;
                r_hold  <= LP_HOLD;
                r_score <= w_score_next;
              end else if (w_last_shot) begin
                r_miss  <= 1'b1;
                r_state <= S_EMPTY;
              end else begin
                r_state <= S_COOL;
              end
            end
          end
          S_COOL: begin
            // Load happened in ARMED, so a coincident frame
            // pulse never shortens the cooldown.
            if (new_frame) begin
              if (r_cd != 6'd0) begin
                r_cd <= r_cd - 6'd1;
              end
              if (r_cd <= 6'd1) begin
                r_state <= S_ARMED;
              end
            end
          end
          S_HOLD: begin
            if (new_frame) begin
              if (r_hold != 4'd0) begin
                r_hold <= r_hold - 4'd1;
              end
              if (r_hold <= 4'd1) begin
                r_state <= S_EMPTY;
                r_hit   <= 1'b0;
              end
            end
          end
          S_EMPTY: begin
            if (w_show_rise) begin
              r_state <= S_ARMED;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_hit   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hit        = r_hit;
  assign shot_fired = r_shot;
  assign shots_left = r_shots_left;
  assign score      = r_score;
  assign miss       = r_miss;

endmodule
